// File: rtl/mux_16bit.sv
// mux_16bit: two-input word multiplexer with a combinational output and a
// registered copy of the selected word for pipelined consumers.
//
// Ports:
//   clk          rising-edge clock for all registers
//   rst          asynchronous active-high reset, clears registered state
//   in0          word selected when select = 0
//   in1          word selected when select = 1
//   select       source select (0 -> in0, 1 -> in1)
//   en           load enable for out_q / sel_q; 0 holds them
//   out          combinational selected word
//   out_q        registered selected word
//   sel_q        select value captured together with out_q
//   sel_changed  one-cycle pulse: last load captured a select different
//                from the previously captured one
module mux_16bit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             select,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_q,
    output logic             sel_changed
);

    // Conditional operator rather than if/else so an unknown select merges
    // in0/in1 bitwise (X only where they differ) instead of picking a side.
    assign out = select ? in1 : in0;

    // Registered copy of the selected word and the select that produced it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            sel_q       <= 1'b0;
            sel_changed <= 1'b0;
        end else if (en) begin
            out_q       <= out;
            sel_q       <= select;
            sel_changed <= (select != sel_q);
        end else begin
            // Hold the data; the change flag only lives for the load cycle.
            sel_changed <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_16bit.sv
// Directed testbench for mux_16bit: reset, select paths, enable hold,
// asynchronous reset mid-run and a walking-ones sweep.
module tb_mux_16bit;

    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             select;
    logic             en;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic             sel_q;
    logic             sel_changed;

    int checks = 0;
    int errors = 0;

    mux_16bit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in0         (in0),
        .in1         (in1),
        .select      (select),
        .en          (en),
        .out         (out),
        .out_q       (out_q),
        .sel_q       (sel_q),
        .sel_changed (sel_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] observed,
                         input logic [WIDTH-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_regs(input string tag, input logic [WIDTH-1:0] exp_q,
                              input logic exp_sel, input logic exp_chg);
        check({tag, "_out_q"}, out_q, exp_q);
        check({tag, "_sel_q"}, 16'(sel_q), 16'(exp_sel));
        check({tag, "_sel_changed"}, 16'(sel_changed), 16'(exp_chg));
    endtask

    initial begin
        logic             prev_sel;
        logic             cur_sel;
        logic [WIDTH-1:0] w0;
        logic [WIDTH-1:0] w1;

        // Reset with zero inputs
        rst = 1'b1; in0 = 16'h0000; in1 = 16'h0000; select = 1'b0; en = 1'b0;
        #12;
        check("reset_out", out, 16'h0000);
        check_regs("reset", 16'h0000, 1'b0, 1'b0);

        // Select in0, load once
        rst = 1'b0; in1 = 16'h0F00; en = 1'b1;
        #1;
        check("sel0_out", out, 16'h0000);
        @(posedge clk); #1;
        check_regs("sel0_load", 16'h0000, 1'b0, 1'b0);

        // Switch to in1 between edges: out follows without a clock
        #3 select = 1'b1;
        #1;
        check("sel1_out_comb", out, 16'h0F00);
        check("sel1_out_q_not_yet", out_q, 16'h0000);
        @(posedge clk); #1;
        check_regs("sel1_load", 16'h0F00, 1'b1, 1'b1);

        // Enable low: data held, change flag drops
        en = 1'b0;
        @(posedge clk); #1;
        check_regs("hold_first", 16'h0F00, 1'b1, 1'b0);

        in1 = 16'hFFFF;
        #1;
        check("hold_out_comb", out, 16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        check_regs("hold_many", 16'h0F00, 1'b1, 1'b0);

        // Reload with the same select: no change pulse
        en = 1'b1;
        @(posedge clk); #1;
        check_regs("same_sel_load", 16'hFFFF, 1'b1, 1'b0);
        en = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset between edges
        in1 = 16'h0F00;
        @(posedge clk); #1;
        en = 1'b1;
        @(posedge clk); #1;
        check("pre_async_out_q", out_q, 16'h0F00);
        en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_regs("async_rst", 16'h0000, 1'b0, 1'b0);
        check("async_rst_out", out, 16'h0F00);
        #1 rst = 1'b0;

        // First load after reset compares against reset sel_q = 0
        en = 1'b1;
        @(posedge clk); #1;
        check_regs("post_rst_load", 16'h0F00, 1'b1, 1'b1);

        // Walking ones with select toggling each step
        prev_sel = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w0 = 16'h0001 << i;
            w1 = ~w0;
            cur_sel = (i % 2) != 0;
            in0 = w0; in1 = w1; select = cur_sel;
            #1;
            check($sformatf("walk%0d_out", i), out, cur_sel ? w1 : w0);
            @(posedge clk); #1;
            check_regs($sformatf("walk%0d", i), cur_sel ? w1 : w0, cur_sel,
                       cur_sel != prev_sel);
            prev_sel = cur_sel;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_16bit.md
# mux_16bit

16-bit two-input word multiplexer used in datapath operand/result selection. A combinational output follows the select line immediately. A registered copy of the selected word, plus the select value that produced it, is provided for pipelined consumers. Sits between register-file/ALU sources and downstream stages that need either a same-cycle or a one-cycle-delayed selected word.

## Interface

Parameters:
- WIDTH, 16, data word width in bits; all data ports use this width.

Ports:
- clk  input  1  sole clock; all registers update on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears all registered state immediately on assertion, independent of clk.
- in0  input  WIDTH  data word selected when select = 0.
- in1  input  WIDTH  data word selected when select = 1.
- select  input  1  source select: 0 chooses in0, 1 chooses in1.
- en  input  1  register load enable for out_q/sel_q; 0 holds the registered state.
- out  output  WIDTH  combinational selected word.
- out_q  output  WIDTH  registered selected word.
- sel_q  output  1  select value captured with out_q.
- sel_changed  output  1  registered flag: 1 when the select captured on the last load differs from the previously captured select.

## Operation

- out = select ? in1 : in0, purely combinational, with no dependence on clk, rst or en.
- If select is X/Z in simulation, out is X for any bit where in0 and in1 differ. No priority or default is applied.
- On a rising clk edge with rst = 0 and en = 1:
  - out_q <= out (the value at the edge).
  - sel_q <= select.
  - sel_changed <= (select != sel_q).
- On a rising clk edge with rst = 0 and en = 0:
  - out_q and sel_q hold.
  - sel_changed <= 0, so the flag is a single-cycle pulse per load.
- Reset values while rst = 1: out_q = 0, sel_q = 0, sel_changed = 0. out still follows the inputs combinationally during reset.
- No arithmetic is performed. Bit i of each output depends only on bit i of in0/in1 plus select; there is no width conversion.

## Timing

- out: zero-cycle latency; changes in the same delta as in0, in1 or select.
- out_q/sel_q: one-cycle latency; they reflect inputs sampled at the rising edge where en = 1.
- rst asserted mid-operation clears registered outputs immediately, without waiting for clk.
- Deassertion of rst: the first rising edge with rst = 0 and en = 1 loads normally. sel_changed on that load compares against the reset value sel_q = 0.
- Simultaneous select change and clk edge: the registered outputs capture the pre-edge (setup-satisfied) values.
- No handshake and no back-pressure. en is the only qualifier.

## Test plan

- Reset/zero inputs: rst = 1, in0 = 0x0000, in1 = 0x0000, select = 0 -> out = 0x0000, out_q = 0x0000, sel_q = 0, sel_changed = 0.
- Select in0: in0 = 0x0000, in1 = 0x0F00, select = 0 -> out = 0x0000 immediately; after one edge with en = 1, out_q = 0x0000, sel_q = 0.
- Select in1: from the previous state, set select = 1 (e.g. at t = 10) -> out = 0x0F00 with no clock edge. The next edge with en = 1 gives out_q = 0x0F00, sel_q = 1, sel_changed = 1. The following edge with en = 0 leaves out_q = 0x0F00 and clears sel_changed to 0.
- Enable hold: en = 0, in1 changes to 0xFFFF with select = 1 -> out = 0xFFFF; out_q stays at 0x0F00 across several edges.
- Asynchronous reset mid-run: out_q = 0x0F00, assert rst between clock edges -> out_q = 0x0000 and sel_q = 0 immediately; out still equals the selected input.
- Walking-ones sweep: in0 = 1 << i, in1 = ~(1 << i) for i = 0..15, with select toggled each step -> out matches the selected word bit-exactly for every i.
